iot_responder: RTL

IOT_RESPONDER -- requirements
Module: iot_responder

---
 rtl/iot_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/iot_responder.sv
// rtl/iot_responder.sv - PDP-8 style IOT responder for keyboard (03) and teleprinter (04) devices.
// Optional IOT_INTERRUPT_EN adds device 00 ION/IOF decoding and the int_req output.
module iot_responder #(
  parameter int PRINT_DELAY = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iot_req,
  input  logic [5:0] iot_dev,
  input  logic [2:0] iot_pulse,
  input  logic [7:0] dataout,
  output logic       iot_done,
  output logic       skip,
  output logic       clear_ac,
  output logic [7:0] datain,
  input  logic       kbd_valid,
  input  logic [7:0] kbd_data,
  output logic       kbd_ready,
  output logic       tto_valid,
  output logic [7:0] tto_data,
  input  logic       tto_ready
`ifdef IOT_INTERRUPT_EN
  ,
  output logic       int_req
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;
  localparam logic [7:0] LAST_COUNT = 8'(PRINT_DELAY - 1);

  logic [1:0] state;
  logic [7:0] count;
  logic       kbd_flag;
  logic       tto_flag;
  logic [7:0] kbd_buf;
  logic       kbd_sel;
  logic       tto_sel;
  logic       kbd_capture;
  logic       print_done;

  assign kbd_sel     = iot_req && (iot_dev == 6'o03);
  assign tto_sel     = iot_req && (iot_dev == 6'o04);
  assign kbd_ready   = !kbd_flag;
  assign kbd_capture = kbd_valid && !kbd_flag;
  assign tto_valid   = (state == ST_SEND);
  assign print_done  = (state == ST_BUSY) && (count == LAST_COUNT);

`ifdef IOT_INTERRUPT_EN
  logic int_sel;
  logic int_en;

  assign int_sel = iot_req && (iot_dev == 6'o00);
  assign int_req = int_en && (kbd_flag || tto_flag);

  always_ff @(posedge clock) begin
    if (reset) begin
      int_en <= 1'b0;
    end else if (int_sel && iot_pulse[1]) begin
      int_en <= 1'b0;
    end else if (int_sel && iot_pulse[0]) begin
      int_en <= 1'b1;
    end
  end
`endif

  // Responses are built from pre-update flag/buffer values, so skip reflects the state before this request.
  always_ff @(posedge clock) begin
    if (reset) begin
      iot_done <= 1'b0;
      skip     <= 1'b0;
      clear_ac <= 1'b0;
      datain   <= 8'd0;
    end else begin
      iot_done <= iot_req;
      skip     <= 1'b0;
      clear_ac <= 1'b0;
      datain   <= 8'd0;
      if (kbd_sel) begin
        skip     <= iot_pulse[0] && kbd_flag;
        clear_ac <= iot_pulse[1];
        datain   <= iot_pulse[2] ? kbd_buf : 8'd0;
      end
      if (tto_sel) begin
        skip <= iot_pulse[0] && tto_flag;
      end
    end
  end

  // A character arriving in the same cycle as a P2 clear wins: the flag ends set.
  always_ff @(posedge clock) begin
    if (reset) begin
      kbd_flag <= 1'b0;
      kbd_buf  <= 8'd0;
    end else if (kbd_capture) begin
      kbd_flag <= 1'b1;
      kbd_buf  <= kbd_data;
    end else if (kbd_sel && iot_pulse[1]) begin
      kbd_flag <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tto_flag <= 1'b0;
    end else if (print_done) begin
      tto_flag <= 1'b1;
    end else if (tto_sel && iot_pulse[1]) begin
      tto_flag <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= 8'd0;
      tto_data <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tto_sel && iot_pulse[2]) begin
            tto_data <= dataout;
            state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (tto_ready) begin
            count <= 8'd0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (print_done) begin
            count <= 8'd0;
            state <= ST_IDLE;
          end else begin
            count <= count + 8'd1;
          end
        end
        default: begin
          count <= 8'd0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
